// File: rtl/wave_acq_pkg.sv
// Shared widths and the shot sequencer state encoding for the wave acquisition block.
package wave_acq_pkg;

  localparam int PERIOD_W = 24;
  localparam int DELAY_W  = 16;
  localparam int PW_W     = 8;
  localparam int SIZE_W   = 12;
  localparam int DATA_W   = 8;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    DELAY,
    CAPTURE
  } state_t;

endpackage

// File: rtl/rep_timer.sv
// Repetition timer: registered one-clock tick every period+1 clocks while enabled.
module rep_timer #(
  parameter int PERIOD_W = wave_acq_pkg::PERIOD_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;

  // Counter restarts from zero whenever enable drops, so the first tick after
  // enabling lands a full period later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == period) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/wave_acq_ctrl.sv
// Ultrasonic shot sequencer: tick -> pulse -> echo delay -> one whole wave into the FIFO.
module wave_acq_ctrl
  import wave_acq_pkg::*;
#(
  parameter int PERIOD_W = wave_acq_pkg::PERIOD_W,
  parameter int DELAY_W  = wave_acq_pkg::DELAY_W,
  parameter int PW_W     = wave_acq_pkg::PW_W,
  parameter int SIZE_W   = wave_acq_pkg::SIZE_W,
  parameter int DATA_W   = wave_acq_pkg::DATA_W,
  parameter int CNT_W    = wave_acq_pkg::CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [PW_W-1:0]     i_pulse_width,
  input  logic [DELAY_W-1:0]  i_delay,
  input  logic [SIZE_W-1:0]   i_wave_size_dec,
  input  logic [DATA_W-1:0]   i_adc_data,
  input  logic                i_fifo_full,
  output logic                o_pulse,
  output logic                o_fifo_wr,
  output logic [DATA_W-1:0]   o_fifo_data,
  output logic [SIZE_W-1:0]   o_wave_size_dec,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_wave_cnt,
  output logic [CNT_W-1:0]    o_drop_cnt
);

  state_t             state;
  logic               tick;
  logic               drop;
  logic [PW_W-1:0]    pulse_cnt;
  logic [DELAY_W-1:0] delay_cnt;
  logic [SIZE_W-1:0]  write_cnt;

  rep_timer #(.PERIOD_W(PERIOD_W)) u_rep_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .enable  (i_enable),
    .period  (i_period),
    .tick    (tick)
  );

  // A tick is lost either to an overrun or to a FIFO with no free wave slot.
  assign drop   = tick && ((state != IDLE) || i_fifo_full);
  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      pulse_cnt       <= '0;
      delay_cnt       <= '0;
      write_cnt       <= '0;
      o_pulse         <= 1'b0;
      o_fifo_wr       <= 1'b0;
      o_fifo_data     <= '0;
      o_wave_size_dec <= '0;
      o_wave_cnt      <= '0;
      o_drop_cnt      <= '0;
    end else begin
      o_fifo_data <= i_adc_data;
      if (drop && (o_drop_cnt != '1)) begin
        o_drop_cnt <= o_drop_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (!i_enable) begin
            o_wave_size_dec <= i_wave_size_dec;
          end
          if (tick && !i_fifo_full) begin
            state     <= PULSE;
            o_pulse   <= 1'b1;
            pulse_cnt <= (i_pulse_width == '0) ? '0 : i_pulse_width - 1'b1;
          end
        end
        PULSE: begin
          if (pulse_cnt == '0) begin
            o_pulse <= 1'b0;
            if (i_delay == '0) begin
              state     <= CAPTURE;
              o_fifo_wr <= 1'b1;
              write_cnt <= o_wave_size_dec;
            end else begin
              state     <= DELAY;
              delay_cnt <= i_delay - 1'b1;
            end
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        DELAY: begin
          if (delay_cnt == '0) begin
            state     <= CAPTURE;
            o_fifo_wr <= 1'b1;
            write_cnt <= o_wave_size_dec;
          end else begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
        CAPTURE: begin
          if (write_cnt == '0) begin
            state      <= IDLE;
            o_fifo_wr  <= 1'b0;
            o_wave_cnt <= o_wave_cnt + 1'b1;
          end else begin
            write_cnt <= write_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_acq_ctrl.sv
// Scoreboard bench: expected pulse/write cycles are queued, a negedge monitor checks them.
module tb_wave_acq_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } wr_exp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] period;
  logic [7:0]  pulse_width;
  logic [15:0] delay;
  logic [11:0] wave_size_dec;
  logic [7:0]  adc_data;
  logic        fifo_full;
  logic        pulse;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic [11:0] wave_size_q;
  logic        busy;
  logic [15:0] wave_cnt;
  logic [15:0] drop_cnt;

  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  int      exp_pulse_q[$];
  wr_exp_t exp_wr_q[$];

  wave_acq_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_enable        (enable),
    .i_period        (period),
    .i_pulse_width   (pulse_width),
    .i_delay         (delay),
    .i_wave_size_dec (wave_size_dec),
    .i_adc_data      (adc_data),
    .i_fifo_full     (fifo_full),
    .o_pulse         (pulse),
    .o_fifo_wr       (fifo_wr),
    .o_fifo_data     (fifo_data),
    .o_wave_size_dec (wave_size_q),
    .o_busy          (busy),
    .o_wave_cnt      (wave_cnt),
    .o_drop_cnt      (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ADC models an incrementing sample: during cycle c it carries c mod 256.
  initial begin
    adc_data = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      adc_data = cyc[7:0];
    end
  end

  task automatic check_value(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_pulses(input int t, input int pw);
    int pwe;
    pwe = (pw == 0) ? 1 : pw;
    for (int i = 1; i <= pwe; i++) exp_pulse_q.push_back(t + i);
  endtask

  // Tick in cycle t: pulses t+1.., then delay clocks, then sz+1 writes of the previous-cycle sample.
  task automatic push_shot(input int t, input int pw, input int d, input int sz);
    int pwe;
    int w0;
    wr_exp_t e;
    pwe = (pw == 0) ? 1 : pw;
    push_pulses(t, pw);
    w0 = t + pwe + d + 1;
    for (int j = 0; j <= sz; j++) begin
      e.cyc  = w0 + j;
      e.data = 8'((w0 + j - 1) & 255);
      exp_wr_q.push_back(e);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic applyStimulus(input int p, input int pw, input int d, input int sz);
    period        = 24'(p);
    pulse_width   = 8'(pw);
    delay         = 16'(d);
    wave_size_dec = 12'(sz);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input int exp_wave, input int exp_drop);
    check_value({tag, " wave_cnt"}, int'(wave_cnt), exp_wave);
    check_value({tag, " drop_cnt"}, int'(drop_cnt), exp_drop);
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, " o_pulse"}, int'(pulse), 0);
    check_value({tag, " o_fifo_wr"}, int'(fifo_wr), 0);
    check_value({tag, " o_fifo_data"}, int'(fifo_data), 0);
    check_value({tag, " o_wave_size_dec"}, int'(wave_size_q), 0);
    check_value({tag, " o_busy"}, int'(busy), 0);
    checkOutput(tag, 0, 0);
  endtask

  // Monitor: every asserted pulse or write must match the head of its queue.
  initial begin
    wr_exp_t e;
    int p;
    forever begin
      @(negedge clk);
      if (pulse) begin
        checks++;
        if (exp_pulse_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected pulse: got pulse at cycle %0d expected none", cyc);
        end else begin
          p = exp_pulse_q.pop_front();
          if (p != cyc) begin
            errors++;
            $display("[TB] FAIL pulse timing: got cycle %0d expected cycle %0d", cyc, p);
          end
        end
      end
      if (fifo_wr) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected write: got data %0d at cycle %0d expected none", fifo_data, cyc);
        end else begin
          e = exp_wr_q.pop_front();
          if (e.cyc != cyc || e.data != fifo_data) begin
            errors++;
            $display("[TB] FAIL fifo write: got cycle %0d data %0d expected cycle %0d data %0d",
                     cyc, fifo_data, e.cyc, e.data);
          end
        end
      end
    end
  end

  initial begin
    int c0;
    int r;
    rst_n         = 1'b0;
    enable        = 1'b0;
    period        = '0;
    pulse_width   = '0;
    delay         = '0;
    wave_size_dec = '0;
    fifo_full     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    $display("[TB] basic shot");
    applyStimulus(99, 3, 5, 7);
    check_value("size latched", int'(wave_size_q), 7);
    enable = 1'b1;
    c0 = cyc;
    push_shot(c0 + 100, 3, 5, 7);
    push_shot(c0 + 200, 3, 5, 7);
    wait_until(c0 + 230);
    enable = 1'b0;
    checkOutput("basic", 2, 0);

    $display("[TB] zero corners");
    applyStimulus(19, 0, 0, 0);
    enable = 1'b1;
    c0 = cyc;
    push_shot(c0 + 20, 0, 0, 0);
    push_shot(c0 + 40, 0, 0, 0);
    wait_until(c0 + 50);
    enable = 1'b0;
    checkOutput("zero", 4, 0);

    $display("[TB] full drop");
    applyStimulus(9, 2, 1, 3);
    fifo_full = 1'b1;
    enable = 1'b1;
    c0 = cyc;
    wait_until(c0 + 35);
    checkOutput("full held", 4, 3);
    check_value("full busy", int'(busy), 0);
    fifo_full = 1'b0;
    push_shot(c0 + 40, 2, 1, 3);
    wait_until(c0 + 45);
    enable = 1'b0;
    wait_until(c0 + 55);
    checkOutput("full release", 5, 3);

    $display("[TB] overrun");
    applyStimulus(9, 1, 0, 31);
    enable = 1'b1;
    c0 = cyc;
    push_shot(c0 + 10, 1, 0, 31);
    wait_until(c0 + 45);
    enable = 1'b0;
    wait_until(c0 + 50);
    checkOutput("overrun", 6, 6);

    $display("[TB] disable mid-capture");
    applyStimulus(49, 2, 3, 7);
    check_value("size relatched", int'(wave_size_q), 7);
    enable = 1'b1;
    c0 = cyc;
    push_shot(c0 + 50, 2, 3, 7);
    wait_until(c0 + 30);
    wave_size_dec = 12'd3;
    wait_until(c0 + 59);
    enable = 1'b0;
    wait_until(c0 + 62);
    check_value("size held busy", int'(wave_size_q), 7);
    wait_until(c0 + 70);
    check_value("size after idle", int'(wave_size_q), 3);
    checkOutput("disable", 7, 6);
    wait_until(c0 + 200);

    $display("[TB] reset in delay");
    applyStimulus(29, 2, 10, 3);
    enable = 1'b1;
    c0 = cyc;
    push_pulses(c0 + 30, 2);
    wait_until(c0 + 36);
    check_value("busy in delay", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_state("async reset");
    wait_until(c0 + 39);
    rst_n = 1'b1;
    r = cyc;
    push_shot(r + 30, 2, 10, 0);
    wait_until(r + 50);
    enable = 1'b0;
    checkOutput("post reset", 1, 0);

    repeat (5) @(negedge clk);
    check_value("pulse queue empty", exp_pulse_q.size(), 0);
    check_value("write queue empty", exp_wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
